display_sequencer: RTL and testbench
====================================

# display_sequencer

Controller that sequences the counter/BCD/7-segment datapath. Debounces the start/stop button and drives the counter run enable. Each display frame it requests one binary-to-BCD conversion, snapshots the 9-digit result, then pages it across the three HEX digits: blank, then high, middle and low groups. It replaces the free-running slow-clock display mux at top level, so a frame always shows one coherent snapshot.

## Interface
- DWELL_CYCLES, 25_000_000: CLOCK_50 cycles each page is held (0.5 s).
- DEBOUNCE_CYCLES, 1_000_000: cycles the button must be stable before a level change is accepted (20 ms).
- CONV_TIMEOUT, 1024: cycles to wait for conv_done before abandoning a conversion.
- CLOCK_50  input  1  system clock; all logic on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- btn_n  input  1  raw start/stop pushbutton, active low, asynchronous to the clock.
- run  output  1  counter enable; toggles on each debounced press.
- conv_start  output  1  one-cycle request to the BCD converter.
- conv_done  input  1  converter result valid, one-cycle pulse.
- bcd_in  input  36  nine BCD digits; [35:32] is the most significant.
- digits  output  12  three digits for HEX2/HEX1/HEX0; [11:8] drives HEX2.
- page_idx  output  2  page shown: 0=blank, 1=high, 2=mid, 3=low.
- frame_start  output  1  one-cycle pulse on entry to BLANK.
- conv_err  output  1  sticky flag, set on a conversion timeout.

## Operation
- Button path:
  - btn_n goes through a 2-flop synchronizer, then the debouncer.
  - The debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Each debounced high-to-low transition toggles run.
  - Release has no effect on run.
- FSM states: CONV, WAIT, BLANK, HI, MID, LO.
- CONV:
  - Assert conv_start for exactly one cycle.
  - Clear the timeout counter.
  - Go to WAIT.
- WAIT:
  - On conv_done, latch bcd_in into the 36-bit snapshot and go to BLANK.
  - If the timeout counter reaches CONV_TIMEOUT-1 without conv_done, set conv_err, keep the previous snapshot and go to BLANK.
- BLANK, HI, MID, LO:
  - Hold the page for DWELL_CYCLES; the dwell counter counts 0..DWELL_CYCLES-1 and advances on terminal count.
  - Transitions: BLANK→HI→MID→LO→CONV.
- Page contents:
  - BLANK: digits=12'hFFF.
  - HI: snapshot[35:24].
  - MID: snapshot[23:12].
  - LO: snapshot[11:0].
- conv_done outside WAIT is ignored.
- A run toggle mid-frame does not alter the current snapshot or page sequence.
- conv_err clears only on reset.

## Timing
- Reset values:
  - run=1, conv_start=0, digits=12'hFFF, page_idx=0, frame_start=0, conv_err=0.
  - snapshot=0, state=CONV, all counters 0.
- conv_start asserts in the first clock edge after reset_n deasserts.
- All outputs are registered. digits and page_idx update on the same edge as the state change.
- conv_done can be accepted no earlier than the cycle after conv_start. Snapshot latency is 1 cycle after conv_done.
- Frame length with an immediate conv_done: 4·DWELL_CYCLES + 2 + converter latency.
- A press registers DEBOUNCE_CYCLES+2 cycles after a clean btn_n fall. run toggles on the following edge.
- Bounce shorter than DEBOUNCE_CYCLES produces no toggle.
- Reset asserted mid-frame or mid-conversion forces all reset values immediately (asynchronous). A late conv_done after reset is ignored because the FSM is in CONV, not WAIT.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - In HI and MID pages, any digit that is zero and whose more-significant snapshot digits are all zero is output as 4'hF (blank).
  - LO page digit [3:0] is always shown.
- LEADING_ZERO_BLANK_EN undefined: snapshot digits are output unmodified.

## Structure
- Package display_seq_pkg holds:
  - state enum.
  - BLANK_DIGIT = 4'hF.
  - page_idx encodings.
  - DIGITS_PER_PAGE = 3.
- Sub-module btn_debounce: synchronizer, debounce counter and falling-edge pulse output. Parameter DEBOUNCE_CYCLES.

## Test plan
Bench parameters: DWELL_CYCLES=4, DEBOUNCE_CYCLES=3, CONV_TIMEOUT=8.

1. Release reset; conv_done with bcd_in=36'h123456789 two cycles after conv_start → frame_start pulse; pages show FFF, 123, 456, 789, 4 cycles each; then conv_start fires again.
2. btn_n low for 5 cycles → run goes 1→0 once. btn_n glitch low for 2 cycles → run unchanged.
3. Converter never responds → after 8 cycles in WAIT, conv_err=1; pages show the previous snapshot; conv_err stays set across frames.
4. With LEADING_ZERO_BLANK_EN and bcd_in=36'h000000045 → HI=FFF, MID=FFF, LO=045.
5. Same input without the macro → HI=000, MID=000, LO=045.
6. Assert reset_n during the MID page → digits=FFF, page_idx=0, run=1 immediately. conv_done pulsed during reset, or in the cycle after release, is ignored.

Source files
------------

// File: rtl/display_seq_pkg.sv
// display_seq_pkg: shared states, page encodings and digit constants for display_sequencer
package display_seq_pkg;
  typedef enum logic [2:0] {
    S_CONV,
    S_WAIT,
    S_BLANK,
    S_HI,
    S_MID,
    S_LO
  } state_t;
  localparam logic [3:0] BLANK_DIGIT = 4'hF;
  localparam logic [1:0] PAGE_BLANK = 2'd0;
  localparam logic [1:0] PAGE_HI = 2'd1;
  localparam logic [1:0] PAGE_MID = 2'd2;
  localparam logic [1:0] PAGE_LO = 2'd3;
  localparam int DIGITS_PER_PAGE = 3;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes and debounces an active-low button, pulsing press on each accepted fall
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic btn_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic level;
  logic [CW-1:0] cnt;
  // Two-flop synchronizer, resting at the released level
  always_ff @(posedge CLOCK_50 or negedge reset_n)
    if (!reset_n) sync <= 2'b11;
    else sync <= {sync[0], btn_n};
  // Adopt the synchronized level once it has disagreed for DEBOUNCE_CYCLES cycles; flag falls
  always_ff @(posedge CLOCK_50 or negedge reset_n)
    if (!reset_n) begin
      level <= 1'b1;
      cnt <= '0;
      press <= 1'b0;
    end else if (sync[1] != level && cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      level <= sync[1];
      cnt <= '0;
      press <= ~sync[1];
    end else begin
      cnt <= sync[1] != level ? cnt + 1'b1 : '0;
      press <= 1'b0;
    end
endmodule

// File: rtl/display_sequencer.sv
// display_sequencer: converts, snapshots and pages a 9-digit BCD value over three HEX digits (option: LEADING_ZERO_BLANK_EN)
module display_sequencer
  import display_seq_pkg::*;
#(
  parameter int DWELL_CYCLES = 25_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CONV_TIMEOUT = 1024
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        btn_n,
  output logic        run,
  output logic        conv_start,
  input  logic        conv_done,
  input  logic [35:0] bcd_in,
  output logic [11:0] digits,
  output logic [1:0]  page_idx,
  output logic        frame_start,
  output logic        conv_err
);
  localparam int DW = $clog2(DWELL_CYCLES + 1);
  localparam int TW = $clog2(CONV_TIMEOUT + 1);
  state_t state, state_d;
  logic [DW-1:0] dwell, dwell_d;
  logic [TW-1:0] tout, tout_d;
  logic [35:0] snap, snap_d, shown;
  logic err_d, press;
  logic [1:0] page_d;
  logic [11:0] digits_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .CLOCK_50(CLOCK_50),
    .reset_n(reset_n),
    .btn_n(btn_n),
    .press(press)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic lead;
  // Zeros ahead of the first nonzero digit in the high and mid groups show blank
  always_comb begin
    shown = snap;
    lead = 1'b1;
    for (int i = 8; i >= 3; i--) begin
      lead = lead & (snap[4*i +: 4] == 4'd0);
      if (lead) shown[4*i +: 4] = BLANK_DIGIT;
    end
  end
`else
  assign shown = snap;
`endif

  // Next state, counters, snapshot capture and the page about to be shown
  always_comb begin
    state_d = state;
    dwell_d = '0;
    tout_d = '0;
    snap_d = snap;
    err_d = conv_err;
    case (state)
      S_CONV: state_d = S_WAIT;
      S_WAIT: begin
        tout_d = tout + 1'b1;
        if (conv_done) begin
          snap_d = bcd_in;
          state_d = S_BLANK;
        end else if (tout == TW'(CONV_TIMEOUT - 1)) begin
          err_d = 1'b1;
          state_d = S_BLANK;
        end
      end
      default: begin
        dwell_d = dwell + 1'b1;
        if (dwell == DW'(DWELL_CYCLES - 1)) begin
          dwell_d = '0;
          state_d = state == S_BLANK ? S_HI : state == S_HI ? S_MID : state == S_MID ? S_LO : S_CONV;
        end
      end
    endcase
    page_d = state_d == S_HI ? PAGE_HI : state_d == S_MID ? PAGE_MID : state_d == S_LO ? PAGE_LO : PAGE_BLANK;
    digits_d = state_d == S_HI ? shown[35:24] : state_d == S_MID ? shown[23:12] :
               state_d == S_LO ? shown[11:0] : {DIGITS_PER_PAGE{BLANK_DIGIT}};
  end

  // State register and registered outputs; outputs change on the same edge as the state
  always_ff @(posedge CLOCK_50 or negedge reset_n)
    if (!reset_n) begin
      state <= S_CONV;
      dwell <= '0;
      tout <= '0;
      snap <= '0;
      run <= 1'b1;
      conv_start <= 1'b0;
      digits <= {DIGITS_PER_PAGE{BLANK_DIGIT}};
      page_idx <= PAGE_BLANK;
      frame_start <= 1'b0;
      conv_err <= 1'b0;
    end else begin
      state <= state_d;
      dwell <= dwell_d;
      tout <= tout_d;
      snap <= snap_d;
      run <= run ^ press;
      conv_start <= state == S_CONV;
      digits <= digits_d;
      page_idx <= page_d;
      frame_start <= state_d == S_BLANK && state != S_BLANK;
      conv_err <= err_d;
    end
endmodule

// File: tb/tb_display_sequencer.sv
// tb_display_sequencer: randomized frame/button stimulus checked against a frame-timeline model
module tb_display_sequencer;
  localparam int DW = 4;
  localparam int DEB = 3;
  localparam int TO = 8;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [11:0] LZ_GROUP = 12'hFFF;
`else
  localparam logic [11:0] LZ_GROUP = 12'h000;
`endif

  logic CLOCK_50 = 1'b0;
  logic reset_n = 1'b0;
  logic btn_n = 1'b1;
  logic conv_done = 1'b0;
  logic [35:0] bcd_in = '0;
  logic run, conv_start, frame_start, conv_err;
  logic [11:0] digits;
  logic [1:0] page_idx;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int t, L;
  int fr = 0;
  int cyc = 0;
  bit resp, err, lvl, fall, run_m;
  bit did_rst = 1'b0;
  logic [35:0] snap, val;
  bit hist[$];
  bit script[$];
  logic [11:0] e_dig;
  logic [1:0] e_pg;
  bit e_cs, e_fs;

  display_sequencer #(.DWELL_CYCLES(DW), .DEBOUNCE_CYCLES(DEB), .CONV_TIMEOUT(TO)) dut (
    .CLOCK_50(CLOCK_50),
    .reset_n(reset_n),
    .btn_n(btn_n),
    .run(run),
    .conv_start(conv_start),
    .conv_done(conv_done),
    .bcd_in(bcd_in),
    .digits(digits),
    .page_idx(page_idx),
    .frame_start(frame_start),
    .conv_err(conv_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d frame %0d t %0d)", nm, act, exp, cyc, fr, t);
    end
  endtask

  // Three digits of page p (1..3), most-significant group first
  function automatic logic [11:0] page_digits(input logic [35:0] s, input int p);
    logic [11:0] r;
    logic [3:0] d;
    int k;
`ifdef LEADING_ZERO_BLANK_EN
    int nlz;
    nlz = 0;
    for (int i = 0; i < 9; i++) if (nlz == i && s[35-4*i -: 4] == 4'd0) nlz++;
`endif
    for (int j = 0; j < 3; j++) begin
      k = (p - 1) * 3 + j;
      d = s[35-4*k -: 4];
`ifdef LEADING_ZERO_BLANK_EN
      if (k < nlz && k < 6) d = 4'hF;
`endif
      r[11-4*j -: 4] = d;
    end
    return r;
  endfunction

  // Frame t=0 is the cycle before conv_start; the response lands L cycles later
  task automatic plan();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    val = r[35:0] >> (4 * $urandom_range(0, 9));
    resp = $urandom_range(0, 4) != 0;
    L = resp ? $urandom_range(2, TO) : TO;
    case (fr)
      0: begin L = 2; resp = 1; val = 36'h123456789; end
      1: begin L = TO; resp = 0; end
      2: begin L = 2; resp = 1; val = 36'h000000045; end
      3: begin L = TO; resp = 1; end
      default: ;
    endcase
  endtask

  task automatic compute_exp();
    e_cs = t == 1;
    e_fs = t == L + 1;
    e_pg = t >= L + 1 ? 2'((t - L - 1) / DW) : 2'd0;
    e_dig = e_pg == 2'd0 ? 12'hFFF : page_digits(snap, int'(e_pg));
  endtask

  task automatic model_reset();
    hist.delete();
    repeat (DEB + 3) hist.push_back(1'b1);
    lvl = 1'b1;
    fall = 1'b0;
    run_m = 1'b1;
    t = 0;
    snap = '0;
    err = 1'b0;
    plan();
    compute_exp();
  endtask

  // Model update for one clock edge using the inputs sampled at that edge
  task automatic advance();
    bit all_diff;
    hist.push_back(btn_n);
    if (hist.size() > 32) void'(hist.pop_front());
    if (fall) run_m = !run_m;
    fall = 1'b0;
    all_diff = 1'b1;
    for (int i = 0; i < DEB; i++) if (hist[hist.size() - 3 - i] == lvl) all_diff = 1'b0;
    if (all_diff) begin
      lvl = !lvl;
      fall = !lvl;
    end
    t++;
    if (t == L + 1) begin
      if (resp) snap = val;
      else err = 1'b1;
    end
    if (t == L + 4 * DW + 1) begin
      t = 0;
      fr++;
      plan();
    end
    compute_exp();
  endtask

  task automatic drive();
    logic [63:0] r;
    if (script.size() == 0) begin
      repeat ($urandom_range(1, 6)) script.push_back(1'b0);
      repeat ($urandom_range(1, 10)) script.push_back(1'b1);
    end
    btn_n = script.pop_front();
    r = {$urandom(), $urandom()};
    bcd_in = r[35:0];
    conv_done = 1'b0;
    if (t == L && resp) begin
      conv_done = 1'b1;
      bcd_in = val;
    end else if ((t == 0 || t > L) && $urandom_range(0, 7) == 0) conv_done = 1'b1;
  endtask

  task automatic literals();
    if (!did_rst) begin
      if (cyc == 1) chk("lit_conv_start", conv_start, 1'b1);
      if (cyc == 3) chk("lit_frame_start", frame_start, 1'b1);
      if (cyc == 3) chk("lit_blank", digits, 12'hFFF);
      if (cyc == 7) chk("lit_hi", digits, 12'h123);
      if (cyc == 11) chk("lit_mid", digits, 12'h456);
      if (cyc == 15) chk("lit_lo", digits, 12'h789);
      if (cyc == 15) chk("lit_lo_page", page_idx, 2'd3);
      if (cyc == 20) chk("lit_reconv", conv_start, 1'b1);
      if (cyc == 9) chk("lit_run_before", run, 1'b1);
      if (cyc == 10) chk("lit_run_press", run, 1'b0);
      if (cyc == 30) chk("lit_run_glitch", run, 1'b0);
      if (cyc == 27) chk("lit_err_not_yet", conv_err, 1'b0);
      if (cyc == 28) chk("lit_timeout_err", conv_err, 1'b1);
      if (cyc == 32) chk("lit_prev_snap", digits, 12'h123);
      if (cyc == 51) chk("lit_lz_hi", digits, LZ_GROUP);
      if (cyc == 51) chk("lit_err_sticky", conv_err, 1'b1);
      if (cyc == 55) chk("lit_lz_mid", digits, LZ_GROUP);
      if (cyc == 59) chk("lit_lz_lo", digits, 12'h045);
    end else if (cyc == 1) chk("lit_post_reset_start", conv_start, 1'b1);
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
    cyc++;
    advance();
    chk_en = 1'b1;
    literals();
    drive();
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_digits"}, digits, 12'hFFF);
    chk({tag, "_page_idx"}, page_idx, 2'd0);
    chk({tag, "_run"}, run, 1'b1);
    chk({tag, "_conv_start"}, conv_start, 1'b0);
    chk({tag, "_frame_start"}, frame_start, 1'b0);
    chk({tag, "_conv_err"}, conv_err, 1'b0);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    #2;
    reset_n = 1'b0;
    btn_n = 1'b1;
    script.delete();
    #1;
    reset_checks("midframe_reset");
    conv_done = 1'b1;
    bcd_in = 36'h987654321;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    fr = 5;
    cyc = 0;
    did_rst = 1'b1;
    model_reset();
  endtask

  always @(negedge CLOCK_50)
    if (chk_en) begin
      chk("digits", digits, e_dig);
      chk("page_idx", page_idx, e_pg);
      chk("conv_start", conv_start, e_cs);
      chk("frame_start", frame_start, e_fs);
      chk("conv_err", conv_err, err);
      chk("run", run, run_m);
    end

  initial begin
    repeat (2) @(posedge CLOCK_50);
    #1;
    reset_checks("reset");
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    model_reset();
    repeat (3) script.push_back(1'b1);
    repeat (5) script.push_back(1'b0);
    repeat (10) script.push_back(1'b1);
    repeat (2) script.push_back(1'b0);
    repeat (10) script.push_back(1'b1);
    while (fr < 30) begin
      step();
      if (fr == 4 && !did_rst && t == L + 2 * DW + 2) do_reset();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
